// File: rtl/regfile_pkg.sv
// Shared widths and the queued write-back entry format for the 8 x 8-bit register file.
package regfile_pkg;
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular load queue with in-place squash by register index; head visible one cycle after push.
// No internal backpressure: the owner must never push when count == DEPTH.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  input  logic                    squash,
  input  logic [ADDR_W-1:0]       squash_idx,
  output logic                    head_vld,
  output wb_entry_t               head,
  output logic [$clog2(DEPTH):0]  count,
  output logic [NUM_REGS-1:0]     live_mask
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_live;

  // A same-cycle squash is younger than the load being pushed.
  assign push_live = push_entry.live && !(squash && (push_entry.idx == squash_idx));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && vld[i] && (mem[i].idx == squash_idx)) mem[i].live <= 1'b0;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr].live <= push_live;
        mem[wr_ptr].idx  <= push_entry.idx;
        mem[wr_ptr].data <= push_entry.data;
        vld[wr_ptr]      <= 1'b1;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_vld = vld[rd_ptr];
  assign head     = mem[rd_ptr];

  always_comb begin
    live_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i].live) live_mask[mem[i].idx] = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: ALU results win (1-cycle latency), loads queue (>=2 cycles), memReady low only when full.
// Optional REGFILE_WB_DROPCOUNT_EN adds a saturating count of squashed loads.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   aluValid,
  input  logic [ADDR_W-1:0]      aluRegister,
  input  logic [DATA_W-1:0]      aluData,
  input  logic                   memValid,
  output logic                   memReady,
  input  logic [ADDR_W-1:0]      memRegister,
  input  logic [DATA_W-1:0]      memData,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      writeRegister,
  output logic [DATA_W-1:0]      writeData,
  output logic [2**ADDR_W-1:0]   pending
`ifdef REGFILE_WB_DROPCOUNT_EN
  ,
  output logic [7:0]             dropCount
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                alu_acc;
  logic                mem_push;
  logic                pop;
  logic                issue_head;
  logic                head_vld;
  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic [CNT_W-1:0]    count;
  logic [NUM_REGS-1:0] live_mask;

  // Register 0 is discarded at acceptance but the load handshake still completes.
  assign alu_acc    = aluValid && (aluRegister != '0);
  assign memReady   = (count != CNT_W'(DEPTH));
  assign mem_push   = memValid && memReady && (memRegister != '0);
  assign pop        = !alu_acc && head_vld;
  assign issue_head = pop && head.live;

  assign push_entry.live = 1'b1;
  assign push_entry.idx  = memRegister;
  assign push_entry.data = memData;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .resetN     (resetN),
    .push       (mem_push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash     (alu_acc),
    .squash_idx (aluRegister),
    .head_vld   (head_vld),
    .head       (head),
    .count      (count),
    .live_mask  (live_mask)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else if (alu_acc) begin
      regWrite      <= 1'b1;
      writeRegister <= aluRegister;
      writeData     <= aluData;
    end else if (issue_head) begin
      regWrite      <= 1'b1;
      writeRegister <= head.idx;
      writeData     <= head.data;
    end else begin
      regWrite      <= 1'b0;
    end
  end

  always_comb begin
    pending = live_mask;
    if (regWrite) pending[writeRegister] = 1'b1;
    pending[0] = 1'b0;
  end

`ifdef REGFILE_WB_DROPCOUNT_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dropCount <= '0;
    end else if (pop && !head.live && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end
`endif
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back unit on the producer side of the 8 x 8-bit register file: it collects results from the ALU and from the memory-load path and drives the register file's single write port (regWrite / writeRegister / writeData), one write per clock. ALU results take priority; load results wait in a small FIFO. Older queued loads to the same register are squashed by newer ALU writes. A pending-register mask is exported for hazard detection in the issue logic.

## Interface
- DEPTH, 4: load FIFO entries (power of two, 2..16)
- DATA_W, 8: data width
- ADDR_W, 3: register index width (8 registers)
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- aluValid  in  1  ALU result present this cycle (no back-pressure)
- aluRegister  in  ADDR_W  ALU destination register
- aluData  in  DATA_W  ALU result
- memValid  in  1  load result offered
- memReady  out  1  load result accepted when memValid && memReady
- memRegister  in  ADDR_W  load destination register
- memData  in  DATA_W  load data
- regWrite  out  1  register file write enable (registered)
- writeRegister  out  ADDR_W  register file write index (registered)
- writeData  out  DATA_W  register file write data (registered)
- pending  out  2^ADDR_W  bit r set while a write to r is queued or on the write port

## Operation
- Destination 0 is discarded at acceptance from either source. It is never queued, never issued and never marked pending. The handshake still completes.
- Load push: memValid && memReady && memRegister != 0 enqueues {register, data} at the tail.
- memReady = (count != DEPTH). It is combinational from the occupancy count only, with no same-cycle pop look-ahead.
- Issue selection each cycle:
  - aluValid && aluRegister != 0: the output stage loads the ALU result.
  - Otherwise, if the FIFO head is valid and live: the output stage loads the head, and the head is popped.
  - Otherwise, if the head is squashed: the head is popped with no write. This costs one cycle.
  - Otherwise: regWrite = 0.
- Squash: an accepted ALU write to r marks every queued entry with register r dead. A load entry pushed in the same cycle with register r is enqueued already dead. Same-cycle ALU results count as younger than same-cycle loads.
- pending[r] is set when either of these holds:
  - any live FIFO entry targets r;
  - regWrite is high with writeRegister == r.
  - pending[0] is always 0.
- The output stage holds no data across idle cycles: regWrite drops to 0 when there is nothing to issue. writeRegister and writeData keep their last values.

## Timing
- Reset (resetN low, asynchronous):
  - regWrite = 0, writeRegister = 0, writeData = 0;
  - FIFO empty, all entries invalid, pending = 0, memReady = 1.
  - Reset mid-operation drops all queued loads.
- ALU latency: accepted in cycle t, regWrite high in cycle t+1.
- Load latency: pushed in cycle t, visible at the head in t+1, earliest regWrite in t+2. Each cycle with an accepted ALU result delays the load by one more cycle.
- Push while full is impossible by construction. Push and pop in the same cycle with count == DEPTH-1 leaves count unchanged.
- Pointers wrap modulo DEPTH. Count is an ADDR-sized value of width clog2(DEPTH)+1.
- pending updates on the same edge as the FIFO and the output stage, so it is valid one cycle after acceptance.

## Configuration
- REGFILE_WB_DROPCOUNT_EN defined:
  - adds output dropCount (8 bits, reset 0);
  - it increments once per squashed entry popped and saturates at 255.
- Not defined: the port and counter are absent. Squash behaviour is identical in both cases.

## Structure
- Package regfile_pkg:
  - constants NUM_REGS = 8, DATA_W = 8, ADDR_W = 3;
  - typedef wb_entry_t {live, register index, data}.
- One sub-module, wb_fifo: a circular buffer of wb_entry_t with push, pop and head outputs. It also has a squash input (register index + strobe) that clears live on all matching entries, including the entry being pushed. It provides a per-register live mask used to build pending.

## Test plan
- Reset with FIFO partly full -> regWrite 0, pending 8'h00, memReady 1 within the reset cycle.
- ALU only, r3 = 8'hA5 at t -> regWrite=1, writeRegister=3, writeData=8'hA5 at t+1; pending[3] high only in t+1.
- Load r5 = 8'h3C with ALU idle -> write at t+2. The same load with 3 consecutive ALU writes to r1 -> the load writes at t+5, with ALU writes in t+1..t+3.
- Fill 4 loads while the ALU is busy every cycle -> memReady low after the 4th push. The 5th memValid is held off. Order is preserved on drain.
- Load r2 = 8'h11 queued, then ALU r2 = 8'h22 -> only 8'h22 is written. The squashed entry is popped with regWrite 0. With the macro defined, dropCount = 1.
- Same-cycle ALU r6 = 8'h01 and load r6 = 8'h02 -> only 8'h01 is written. Writes to r0 from either source produce no regWrite and no pending bit.
